// File: rtl/stream_seq_checker.sv
// Stream sink that accepts an incrementing sequence (0, 1, 2, ... mod 2^W) and reports done/pass.
// Define STREAM_SEQ_CHECKER_CONTINUE_EN to keep running through mismatches instead of failing at once.
module stream_seq_checker #(
  parameter int unsigned W         = 16,
  parameter int unsigned NUM_WORDS = 65536,
  parameter int unsigned TIMEOUT   = 1000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         throttle,
  input  logic         inValid,
  input  logic [W-1:0] dIn,
  output logic         inReady,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  errCount,
  output logic [31:0]  wordCount,
  output logic [W-1:0] expected
);

  // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED        = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK   = 16'hB400;
  localparam logic [31:0] LAST_WORD   = 32'(NUM_WORDS - 1);
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsrNext;
  logic [31:0] idleCount;
  logic [15:0] errNext;
  logic        xfer;
  logic        mismatch;
  logic        finish;
  logic        finishOk;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    lfsrNext = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
    xfer     = (state == RUN) && inValid && inReady;
    mismatch = xfer && (dIn != expected);
    errNext  = (errCount == 16'hFFFF) ? errCount : errCount + 16'd1;
    finish   = 1'b0;
    finishOk = 1'b0;
    if (state == RUN) begin
      if (xfer) begin
`ifdef STREAM_SEQ_CHECKER_CONTINUE_EN
        finish   = (wordCount == LAST_WORD);
        finishOk = !mismatch && (errCount == 16'd0);
`else
        finish   = mismatch || (wordCount == LAST_WORD);
        finishOk = !mismatch;
`endif
      end else begin
        // A transfer in the same cycle always wins over the timeout.
        finish   = (idleCount + 32'd1) == TIMEOUT_LIM;
        finishOk = 1'b0;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      inReady   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      errCount  <= 16'd0;
      wordCount <= 32'd0;
      expected  <= '0;
      idleCount <= 32'd0;
      lfsr      <= SEED;
    end else begin
      case (state)
        IDLE: begin
          inReady <= 1'b0;
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            inReady   <= 1'b1;
            lfsr      <= SEED;
            errCount  <= 16'd0;
            wordCount <= 32'd0;
            expected  <= '0;
            idleCount <= 32'd0;
          end
        end

        RUN: begin
          lfsr    <= lfsrNext;
          inReady <= throttle ? lfsrNext[0] : 1'b1;
          if (xfer) begin
            wordCount <= wordCount + 32'd1;
            idleCount <= 32'd0;
            if (mismatch) begin
              errCount <= errNext;
            end
`ifdef STREAM_SEQ_CHECKER_CONTINUE_EN
            expected <= mismatch ? dIn + W'(1) : expected + W'(1);
`else
            if (!mismatch) begin
              expected <= expected + W'(1);
            end
`endif
          end else begin
            idleCount <= idleCount + 32'd1;
          end
          if (finish) begin
            state   <= finishOk ? PASS : FAIL;
            inReady <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= finishOk;
          end
        end

        PASS, FAIL: begin
          inReady <= 1'b0;
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_seq_checker.sv
// Randomized checker bench: a transaction-level model of the sink is compared every cycle,
// plus directed checks for latency, LFSR backpressure, mismatch, timeout, reset and wrap.
module tb_stream_seq_checker;

  localparam int unsigned A_WORDS   = 16;
  localparam int unsigned A_TIMEOUT = 20;
  localparam logic [15:0] A_SEED    = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, throttle, inValid;
  logic [15:0] dIn;
  logic        inReady, busy, done, pass;
  logic [15:0] errCount;
  logic [31:0] wordCount;
  logic [15:0] expected;

  logic        bStart, bValid;
  logic [3:0]  bDin;
  logic        bInReady, bBusy, bDone, bPass;
  logic [15:0] bErrCount;
  logic [31:0] bWordCount;
  logic [3:0]  bExpected;

  stream_seq_checker #(.W(16), .NUM_WORDS(A_WORDS), .TIMEOUT(A_TIMEOUT), .LFSR_SEED(A_SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .throttle(throttle), .inValid(inValid), .dIn(dIn),
    .inReady(inReady), .busy(busy), .done(done), .pass(pass),
    .errCount(errCount), .wordCount(wordCount), .expected(expected)
  );

  stream_seq_checker #(.W(4), .NUM_WORDS(40)) dutWrap (
    .clk(clk), .rst(rst), .start(bStart), .throttle(1'b0), .inValid(bValid), .dIn(bDin),
    .inReady(bInReady), .busy(bBusy), .done(bDone), .pass(bPass),
    .errCount(bErrCount), .wordCount(bWordCount), .expected(bExpected)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: tracks the run as a phase plus plain counters.
  typedef enum {M_IDLE, M_RUN, M_PASS, M_FAIL} phase_t;
  phase_t      mPhase;
  bit          mReady;
  bit [15:0]   mLfsr;
  bit [15:0]   mExp;
  int unsigned mErr, mWords, mQuiet;
  bit          mXfer;

  function automatic bit [15:0] lfsrAdvance(input bit [15:0] x);
    bit [15:0] y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  task automatic modelReset();
    mPhase = M_IDLE; mReady = 0; mLfsr = A_SEED;
    mExp = 0; mErr = 0; mWords = 0; mQuiet = 0; mXfer = 0;
  endtask

  task automatic endAs(input bit ok);
    mPhase = ok ? M_PASS : M_FAIL;
    mReady = 0;
  endtask

  task automatic modelStep();
    bit bad;
    mXfer = 0;
    case (mPhase)
      M_IDLE: if (start) begin
        mPhase = M_RUN; mReady = 1; mLfsr = A_SEED;
        mExp = 0; mErr = 0; mWords = 0; mQuiet = 0;
      end
      M_RUN: begin
        mXfer = inValid && mReady;
        mLfsr = lfsrAdvance(mLfsr);
        mReady = throttle ? mLfsr[0] : 1'b1;
        if (mXfer) begin
          mWords++;
          mQuiet = 0;
          bad = (dIn != mExp);
          if (bad && mErr < 16'hFFFF) mErr++;
`ifdef STREAM_SEQ_CHECKER_CONTINUE_EN
          mExp = bad ? dIn + 16'd1 : mExp + 16'd1;
          if (mWords == A_WORDS) endAs(mErr == 0);
`else
          if (bad) endAs(0);
          else begin
            mExp = mExp + 16'd1;
            if (mWords == A_WORDS) endAs(1);
          end
`endif
        end else begin
          mQuiet++;
          if (mQuiet == A_TIMEOUT) endAs(0);
        end
      end
      default: if (!start) mPhase = M_IDLE;
    endcase
  endtask

  task automatic compareAll(input string tag);
    check({tag, "_inReady"}, inReady, mReady);
    check({tag, "_flags"}, {busy, done, pass},
          {mPhase == M_RUN, mPhase == M_PASS || mPhase == M_FAIL, mPhase == M_PASS});
    check({tag, "_errCount"}, errCount, mErr);
    check({tag, "_wordCount"}, wordCount, mWords);
    check({tag, "_expected"}, expected, mExp);
  endtask

  // Counting source and its knobs.
  logic [15:0] srcNext;
  int sent, skipAt, stopAfter, cycle, lastXfer;
  bit validRand, throttleRand, throttleFix;

  task automatic driveSource();
    if (stopAfter >= 0 && sent >= stopAfter) inValid = 1'b0;
    else inValid = validRand ? 1'($urandom_range(0, 1)) : 1'b1;
    dIn = inValid ? srcNext : 16'($urandom);
    throttle = throttleRand ? 1'($urandom_range(0, 1)) : throttleFix;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    modelStep();
    #1;
    compareAll(tag);
    cycle++;
    if (mXfer) begin
      sent++;
      srcNext++;
      if (sent == skipAt) srcNext++;
      lastXfer = cycle;
    end
    driveSource();
  endtask

  task automatic beginRun(input bit vRand, input bit tRand, input bit tFix, input int skip, input int stop);
    validRand = vRand; throttleRand = tRand; throttleFix = tFix;
    skipAt = skip; stopAfter = stop; srcNext = 0; sent = 0;
    start = 1'b1;
    driveSource();
  endtask

  task automatic runToDone(input string tag, input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      tick(tag);
      if (done) break;
    end
    check({tag, "_reached_done"}, done, 1'b1);
  endtask

  task automatic endRun(input string tag);
    start = 1'b0;
    tick(tag);
    check({tag, "_idle_ready_low"}, inReady, 1'b0);
  endtask

  int startCycle;
  int bXfers;
  logic bRdyBefore;

  initial begin
    rst = 1'b0; start = 1'b0; throttle = 1'b0; inValid = 1'b0; dIn = '0;
    bStart = 1'b0; bValid = 1'b0; bDin = '0;
    cycle = 0; lastXfer = 0; sent = 0; skipAt = -1; stopAfter = -1; srcNext = 0;
    validRand = 0; throttleRand = 0; throttleFix = 0;
    modelReset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_inReady", inReady, 1'b0);
    check("reset_flags", {busy, done, pass}, 3'b000);
    check("reset_counts", {errCount, wordCount[15:0]}, 32'd0);
    check("reset_expected", expected, 16'd0);
    @(negedge clk) rst = 1'b0;

    // Full-rate run: ready one cycle after start, 16 transfers in 16 cycles.
    beginRun(0, 0, 0, -1, -1);
    tick("t1_start");
    check("t1_ready_after_start", inReady, 1'b1);
    startCycle = cycle;
    runToDone("t1", 100);
    check("t1_cycles", cycle - startCycle, 16);
    check("t1_pass", {done, pass}, 2'b11);
    check("t1_wordCount", wordCount, 32'd16);
    endRun("t1_end");

    // LFSR backpressure; the model checks inReady bit-exactly every cycle.
    beginRun(0, 0, 1, -1, -1);
    tick("t2_start");
    runToDone("t2", 200);
    check("t2_pass", pass, 1'b1);
    check("t2_ready_in_pass", inReady, 1'b0);
    endRun("t2_end");

    // Sequence 0,1,2,4.
    beginRun(0, 0, 0, 3, -1);
    tick("t3_start");
    runToDone("t3", 100);
    check("t3_pass_low", {done, pass}, 2'b10);
    check("t3_errCount", errCount, 16'd1);
`ifdef STREAM_SEQ_CHECKER_CONTINUE_EN
    check("t3_wordCount", wordCount, 32'd16);
    check("t3_expected", expected, 16'd17);
`else
    check("t3_wordCount", wordCount, 32'd4);
    check("t3_expected", expected, 16'd3);
`endif
    endRun("t3_end");

    // Source stalls after 6 words: timeout exactly 20 cycles after the last transfer.
    beginRun(0, 0, 0, -1, 6);
    tick("t4_start");
    runToDone("t4", 100);
    check("t4_timeout_gap", cycle - lastXfer, 20);
    check("t4_wordCount", wordCount, 32'd6);
    check("t4_pass_low", {done, pass}, 2'b10);
    endRun("t4_end");

    // Reset in the middle of a run, then a clean restart.
    beginRun(0, 0, 0, -1, -1);
    tick("t5_start");
    for (int i = 0; i < 50 && sent < 5; i++) tick("t5_pre");
    check("t5_sent_five", sent, 5);
    #2 rst = 1'b1;
    #1;
    check("t5_async_inReady", inReady, 1'b0);
    check("t5_async_flags", {busy, done, pass}, 3'b000);
    check("t5_async_errCount", errCount, 16'd0);
    check("t5_async_wordCount", wordCount, 32'd0);
    check("t5_async_expected", expected, 16'd0);
    modelReset();
    @(negedge clk) rst = 1'b0;
    srcNext = 0; sent = 0;
    driveSource();
    tick("t5_restart");
    runToDone("t5", 100);
    check("t5_pass", pass, 1'b1);
    check("t5_wordCount", wordCount, 32'd16);
    endRun("t5_end");

    // Randomized valid and throttle, model-checked every cycle.
    for (int r = 0; r < 4; r++) begin
      beginRun(1, 1, 0, (r == 2) ? 7 : -1, -1);
      tick("rnd_start");
      runToDone("rnd", 600);
      endRun("rnd_end");
    end

    // W=4, 40 words: expected wraps 15->0 twice and ends at 8.
    bStart = 1'b1; bValid = 1'b1; bDin = 4'd0; bXfers = 0;
    for (int i = 0; i < 100 && !bDone; i++) begin
      bRdyBefore = bInReady;
      @(posedge clk);
      #1;
      if (bRdyBefore && bValid) begin
        bXfers++;
        bDin = bDin + 4'd1;
        if (bXfers == 16 || bXfers == 32) check("t6_wrap", bExpected, 4'd0);
      end
    end
    check("t6_pass", {bDone, bPass}, 2'b11);
    check("t6_expected", bExpected, 4'd8);
    check("t6_wordCount", bWordCount, 32'd40);
    check("t6_errCount", bErrCount, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stream_seq_checker.md
Name: stream_seq_checker

Overview:
- Synthesizable sink for the valid/ready stream protocol used by the register-slice and FIFO blocks.
- Drives `inReady`, optionally throttled by an LFSR to create backpressure.
- Checks that incoming data is an incrementing sequence starting at 0, modulo 2^W, and reports `done`/`pass`.
- Pairs with an upstream counting source for on-chip and simulation loopback tests of stream paths.

Parameters:
- W, 16: data width.
- NUM_WORDS, 65536: words to accept before declaring pass; legal range 1..2^32-1.
- TIMEOUT, 1000: consecutive RUN cycles without a transfer before declaring fail; must be ≥1.
- LFSR_SEED, 16'hACE1: LFSR reset/start value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; high in IDLE begins a run.
- throttle  in  1  1 = `inReady` follows the LFSR; 0 = `inReady` held high in RUN.
- inValid  in  1  upstream data valid.
- dIn  in  W  upstream data.
- inReady  out  1  registered ready to upstream.
- busy  out  1  high in RUN.
- done  out  1  high in PASS or FAIL.
- pass  out  1  high only in PASS.
- errCount  out  16  mismatches seen this run.
- wordCount  out  32  transfers accepted this run.
- expected  out  W  next expected datum.

Behaviour:
- Transfer = `inValid` && `inReady` sampled at a rising edge of `clk`.
- State machine: IDLE, RUN, PASS, FAIL.
- Reset (async, immediate):
  - state = IDLE.
  - `inReady`, `busy`, `done`, `pass` = 0.
  - `errCount`, `wordCount`, `expected`, timeout counter = 0.
  - lfsr = seed.
- IDLE:
  - `inReady` = 0.
  - When `start` = 1: go to RUN next edge; clear counters, `expected` and timeout counter; reload lfsr = seed.
  - `inReady` first rises on that same edge (1-cycle latency from `start`).
- RUN:
  - `inReady` is registered: next `inReady` = `throttle` ? lfsr_next[0] : 1.
  - The LFSR is 16-bit Galois, mask 16'hB400, and advances every RUN cycle only.
- On a transfer:
  - `wordCount`++.
  - Timeout counter cleared.
  - If `dIn` == `expected`: `expected` = `expected` + 1, wrapping at 2^W.
  - If `dIn` != `expected`: `errCount`++, saturating at 16'hFFFF, and the result is per the optional feature.
- No transfer in a RUN cycle: timeout counter++. When it reaches TIMEOUT, go to FAIL.
- Termination:
  - Transfer with `wordCount` == NUM_WORDS-1 and no mismatch → PASS.
  - Mismatch on the final word → FAIL.
- Simultaneous transfer and timeout in the same cycle: the transfer wins; the timeout counter is cleared.
- PASS/FAIL:
  - `inReady` = 0 on the same edge the state is entered; no further transfers.
  - `done` = 1; `pass` = 1 only in PASS.
  - Counters and `expected` hold their values.
- Leaving PASS/FAIL:
  - Return to IDLE when `start` = 0.
  - A new run requires `start` to go low, then high again.
- `dIn` is ignored whenever there is no transfer.
- Reset asserted mid-run: all outputs go to their reset values immediately; an in-flight word is discarded.

Optional Feature:
- Macro: STREAM_SEQ_CHECKER_CONTINUE_EN.
- Defined:
  - A mismatch does not terminate the run.
  - `expected` resynchronises to `dIn` + 1.
  - The run ends after NUM_WORDS transfers: PASS if `errCount` == 0, else FAIL.
- Undefined:
  - The first mismatch goes to FAIL on that edge.
  - `expected` holds the mismatched expected value.
  - `errCount` ends at 1.

Test Plan:
1. NUM_WORDS=16, `throttle`=0, source always valid with 0..15 → `inReady`=1 one cycle after `start`; 16 transfers in 16 consecutive cycles; `done`=1, `pass`=1, `wordCount`=16 on the next cycle.
2. `throttle`=1, seed 16'hACE1, source always valid → `inReady` pattern matches a bit-exact model of the LFSR; PASS after 16 transfers; `inReady`=0 in IDLE and PASS.
3. Source sends 0,1,2,4 → macro undefined: FAIL after the 4th transfer, `errCount`=1, `expected`=3. Macro defined: run continues with `expected`=5, ends FAIL with `errCount`=1 after 16 words.
4. TIMEOUT=20, source stops after word 5 → FAIL exactly 20 cycles after the last transfer; `wordCount`=6.
5. Assert `rst` after 5 transfers, then restart with `start` → outputs zero asynchronously; the new run passes from 0.
6. W=4, NUM_WORDS=40 → `expected` wraps 15→0 twice; PASS, `expected`=8.
